// File: rtl/bp_types_pkg.sv
// rtl/bp_types_pkg.sv - shared types and helpers for the branch target predictor
package bp_types_pkg;

    // Default geometry, used for the reference entry layout below.
    localparam int BP_ENTRIES_DEF = 16;
    localparam int BP_CNT_W_DEF   = 2;
    localparam int BP_WORD_W_DEF  = 32;
    localparam int BP_IDX_W_DEF   = $clog2(BP_ENTRIES_DEF);
    localparam int BP_TAG_W_DEF   = BP_WORD_W_DEF - 2 - BP_IDX_W_DEF;

    // Reference entry layout at default geometry; the top builds the same
    // field order from its own parameters.
    typedef struct packed {
        logic                     valid;
        logic [BP_TAG_W_DEF-1:0]  tag;
        logic [BP_WORD_W_DEF-1:0] target;
        logic [BP_CNT_W_DEF-1:0]  cnt;
    } bp_entry_t;

    // Index width of a table with the given number of entries.
    function automatic int idx_w(input int entries);
        return $clog2(entries);
    endfunction

    // Tag width: everything above the index, excluding the byte offset.
    function automatic int tag_w(input int word_w, input int entries);
        return word_w - 2 - $clog2(entries);
    endfunction

    // Weakly taken: MSB set, rest clear (1 when the counter is one bit wide).
    function automatic logic [31:0] cnt_weak_taken(input int cnt_w);
        return 32'd1 << (cnt_w - 1);
    endfunction

    // Weakly not taken: MSB clear, rest set (0 when the counter is one bit wide).
    function automatic logic [31:0] cnt_weak_nt(input int cnt_w);
        return cnt_weak_taken(cnt_w) - 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - combinational saturating up/down counter next-value
module sat_counter #(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    // Step toward the outcome, holding at all-ones or zero.
    always_comb begin
        cnt_o = cnt_i;
        if (inc_i) begin
            if (cnt_i != {CNT_W{1'b1}}) begin
                cnt_o = cnt_i + CNT_W'(1);
            end
        end else begin
            if (cnt_i != '0) begin
                cnt_o = cnt_i - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - direct-mapped BTB with saturating counters and perf counters
module branch_target_predictor
    import bp_types_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int WORD_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WORD_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [WORD_W-1:0] pred_npc,
    input  logic              upd_en,
    input  logic [WORD_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [WORD_W-1:0] upd_target,
    input  logic              upd_mispredict,
    input  logic              inv_all,
    output logic [31:0]       branch_cnt,
    output logic [31:0]       mispred_cnt
);

    localparam int IDX_W = idx_w(ENTRIES);
    localparam int TAG_W = tag_w(WORD_W, ENTRIES);
    localparam logic [CNT_W-1:0] CNT_WT = CNT_W'(cnt_weak_taken(CNT_W));
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'(cnt_weak_nt(CNT_W));

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [WORD_W-1:0] target;
        logic [CNT_W-1:0]  cnt;
    } entry_t;

    entry_t table_q [ENTRIES];
    entry_t table_d [ENTRIES];

    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    entry_t           lk_entry;
    entry_t           upd_entry;
    logic             upd_hit;
    logic [CNT_W-1:0] cnt_next;

    // Byte-offset bits of word-aligned PCs carry no information.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign lk_idx    = lookup_pc[IDX_W+1:2];
    assign lk_tag    = lookup_pc[WORD_W-1:IDX_W+2];
    assign upd_idx   = upd_pc[IDX_W+1:2];
    assign upd_tag   = upd_pc[WORD_W-1:IDX_W+2];
    assign lk_entry  = table_q[lk_idx];
    assign upd_entry = table_q[upd_idx];
    assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_sat_counter (
        .cnt_i (upd_entry.cnt),
        .inc_i (upd_taken),
        .cnt_o (cnt_next)
    );

    // Same-cycle lookup from registered state only; an update this cycle is not visible.
    always_comb begin
        pred_hit   = lk_entry.valid && (lk_entry.tag == lk_tag);
        pred_taken = pred_hit && lk_entry.cnt[CNT_W-1];
        pred_npc   = pred_taken ? lk_entry.target : (lookup_pc + WORD_W'(4));
    end

    // Table next state: a flush wins over a same-cycle training update.
    always_comb begin
        table_d = table_q;
        if (inv_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_d[i].valid = 1'b0;
            end
        end else if (upd_en) begin
            if (upd_hit) begin
                table_d[upd_idx].cnt = cnt_next;
                if (upd_taken) begin
                    table_d[upd_idx].target = upd_target;
                end
            end else if (upd_taken) begin
                table_d[upd_idx].valid  = 1'b1;
                table_d[upd_idx].tag    = upd_tag;
                table_d[upd_idx].target = upd_target;
                table_d[upd_idx].cnt    = CNT_WT;
            end
        end
    end

    // Table registers; reset leaves every entry invalid and weakly not taken.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i].valid  <= 1'b0;
                table_q[i].tag    <= '0;
                table_q[i].target <= '0;
                table_q[i].cnt    <= CNT_WNT;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= table_d[i];
            end
        end
    end

    // Perf counters count every retired branch, even one dropped by a flush.
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd_en) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
            if (upd_mispredict) begin
                mispred_cnt_d = mispred_cnt_q + 32'd1;
            end
        end
    end

    // Perf counter registers, wrapping silently.
    always_ff @(posedge CLK) begin
        if (RST) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// tb/tb_branch_target_predictor.sv - vector table and scoreboard bench for branch_target_predictor
module tb_branch_target_predictor;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] lookup_pc = '0;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_npc;
    logic        upd_en = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_mispredict = 1'b0;
    logic        inv_all = 1'b0;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    branch_target_predictor #(
        .ENTRIES (16),
        .CNT_W   (2),
        .WORD_W  (32)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .lookup_pc      (lookup_pc),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_npc       (pred_npc),
        .upd_en         (upd_en),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict),
        .inv_all        (inv_all),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          id;
        logic        rst;
        logic        inv;
        logic [31:0] lpc;
        logic        ue;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utg;
        logic        um;
        logic        eh;
        logic        et;
        logic [31:0] enpc;
        logic [31:0] eb;
        logic [31:0] em;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   vid = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    function automatic vec_t mk(input logic rst, input logic inv, input logic [31:0] lpc,
                                input logic ue, input logic [31:0] upc, input logic ut,
                                input logic [31:0] utg, input logic um,
                                input logic eh, input logic et, input logic [31:0] enpc,
                                input logic [31:0] eb, input logic [31:0] em);
        vec_t v;
        v.id = vid; vid++;
        v.rst = rst; v.inv = inv; v.lpc = lpc;
        v.ue = ue; v.upc = upc; v.ut = ut; v.utg = utg; v.um = um;
        v.eh = eh; v.et = et; v.enpc = enpc; v.eb = eb; v.em = em;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        @(posedge CLK);
        #1;
        RST            = v.rst;
        inv_all        = v.inv;
        lookup_pc      = v.lpc;
        upd_en         = v.ue;
        upd_pc         = v.upc;
        upd_taken      = v.ut;
        upd_target     = v.utg;
        upd_mispredict = v.um;
        sb.push_back(v);
    endtask

    // Outputs seen before the next edge reflect state before this cycle's update.
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            vec_t e;
            e = sb.pop_front();
            n_vec++;
            if (pred_hit !== e.eh || pred_taken !== e.et || pred_npc !== e.enpc ||
                branch_cnt !== e.eb || mispred_cnt !== e.em) begin
                n_miss++;
                $display("FAIL vec%0d hit=%0b/%0b taken=%0b/%0b npc=%h/%h bcnt=%0d/%0d mcnt=%0d/%0d (got/exp)",
                         e.id, pred_hit, e.eh, pred_taken, e.et, pred_npc, e.enpc,
                         branch_cnt, e.eb, mispred_cnt, e.em);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, first allocation and counter training on 0x40.
        vecs.push_back(mk(0,0,32'h40,       0,32'h0, 0,32'h0,  0, 0,0,32'h44,  0,0));
        vecs.push_back(mk(0,0,32'h40,       1,32'h40,1,32'h100,1, 0,0,32'h44,  0,0));
        vecs.push_back(mk(0,0,32'h40,       1,32'h40,1,32'h100,0, 1,1,32'h100, 1,1));
        vecs.push_back(mk(0,0,32'h40,       1,32'h40,1,32'h100,0, 1,1,32'h100, 2,1));
        vecs.push_back(mk(0,0,32'h40,       1,32'h40,0,32'h0,  1, 1,1,32'h100, 3,1));
        vecs.push_back(mk(0,0,32'h40,       1,32'h40,0,32'h0,  1, 1,1,32'h100, 4,2));
        vecs.push_back(mk(0,0,32'h40,       0,32'h0, 0,32'h0,  0, 1,0,32'h44,  5,3));
        // Alias 0x80 onto the same index, evicting 0x40.
        vecs.push_back(mk(0,0,32'h80,       1,32'h80,1,32'h200,1, 0,0,32'h84,  5,3));
        vecs.push_back(mk(0,0,32'h40,       0,32'h0, 0,32'h0,  0, 0,0,32'h44,  6,4));
        vecs.push_back(mk(0,0,32'h80,       0,32'h0, 0,32'h0,  0, 1,1,32'h200, 6,4));
        vecs.push_back(mk(0,0,32'h80,       1,32'h80,0,32'h0,  0, 1,1,32'h200, 6,4));
        vecs.push_back(mk(0,0,32'h80,       0,32'h0, 0,32'h0,  0, 1,0,32'h84,  7,4));
        // Taken hit retargets the entry.
        vecs.push_back(mk(0,0,32'h80,       1,32'h80,1,32'h300,0, 1,0,32'h84,  7,4));
        vecs.push_back(mk(0,0,32'h80,       0,32'h0, 0,32'h0,  0, 1,1,32'h300, 8,4));
        // Not-taken miss must not allocate.
        vecs.push_back(mk(0,0,32'hC4,       1,32'hC4,0,32'h0,  0, 0,0,32'hC8,  8,4));
        vecs.push_back(mk(0,0,32'hC4,       0,32'h0, 0,32'h0,  0, 0,0,32'hC8,  9,4));
        // Fall-through adder wraps.
        vecs.push_back(mk(0,0,32'hFFFFFFFC, 0,32'h0, 0,32'h0,  0, 0,0,32'h0,   9,4));
        // Flush with concurrent update: table empty, counters still advance.
        vecs.push_back(mk(0,1,32'h80,       1,32'h40,1,32'h500,1, 1,1,32'h300, 9,4));
        vecs.push_back(mk(0,0,32'h80,       0,32'h0, 0,32'h0,  0, 0,0,32'h84,  10,5));
        vecs.push_back(mk(0,0,32'h40,       0,32'h0, 0,32'h0,  0, 0,0,32'h44,  10,5));

        repeat (2) @(posedge CLK);
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // Five updates with two mispredicts, then reset with a concurrent update.
        apply(mk(1,0,32'h40, 0,32'h0, 0,32'h0,  0, 0,0,32'h44,  10,5));
        apply(mk(0,0,32'h10, 1,32'h40,1,32'h100,1, 0,0,32'h14,  0,0));
        apply(mk(0,0,32'h10, 1,32'h40,1,32'h100,0, 0,0,32'h14,  1,1));
        apply(mk(0,0,32'h10, 1,32'h48,0,32'h0,  1, 0,0,32'h14,  2,1));
        apply(mk(0,0,32'h10, 1,32'h4C,1,32'h900,0, 0,0,32'h14,  3,2));
        apply(mk(0,0,32'h4C, 1,32'h40,0,32'h0,  0, 1,1,32'h900, 4,2));
        apply(mk(1,0,32'h40, 1,32'h4C,1,32'hA00,1, 1,1,32'h100, 5,2));
        apply(mk(0,0,32'h40, 0,32'h0, 0,32'h0,  0, 0,0,32'h44,  0,0));
        apply(mk(0,0,32'h4C, 0,32'h0, 0,32'h0,  0, 0,0,32'h50,  0,0));

        @(negedge CLK);
        #1;
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
